irq_priority_sequencer: RTL and testbench

- Upstream stage of the PIC control logic. Holds the interrupt request register (IRR) and the in-service register (ISR), and runs the priority resolver.
- Sequences the two-pulse INTA acknowledge and applies end-of-interrupt (EOI) and rotation commands.
- Drives `isr` and `number_of_ack` into the control logic, which forms and sends the vector from them.
- Fully synchronous to one clock; IR inputs are asynchronous and are synchronised internally.

---
 rtl/pic_pkg.sv | 35 +++
 rtl/priority_resolver.sv | 31 +++
 rtl/irq_priority_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_irq_priority_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// ----------------------------------------------------------------------------
// Module : pic_pkg
// Brief  : Shared constants and helpers for the PIC request/service sequencer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pic_pkg;

   localparam int          NUM_IR         = 8;
   localparam logic [2:0]  SPURIOUS_LEVEL = 3'd7;

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_ACK1 = 2'd1;
   localparam logic [1:0]  ST_ACK2 = 2'd2;

   // OCW2 {R,SL,EOI}
   localparam logic [2:0]  OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0]  OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0]  OCW2_NOP          = 3'b010;
   localparam logic [2:0]  OCW2_S_EOI        = 3'b011;
   localparam logic [2:0]  OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0]  OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0]  OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0]  OCW2_ROT_S_EOI    = 3'b111;

   // Rank 0 is the highest priority, i.e. the level just above lowest_prio.
   function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                            input logic [2:0] lowest);
      return level - lowest - 3'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/priority_resolver.sv
// ----------------------------------------------------------------------------
// Module : priority_resolver
// Brief  : Rotating-priority resolver; returns the highest-priority set level.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module priority_resolver
   import pic_pkg::*;
(
   input  logic [NUM_IR-1:0] req,
   input  logic [2:0]        lowest_prio,
   output logic              valid,
   output logic [2:0]        level
);

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      valid = 1'b0;
      level = SPURIOUS_LEVEL;
      for (int k = NUM_IR - 1; k >= 0; k--) begin
         if (req[lowest_prio + 3'(k + 1)]) begin
            valid = 1'b1;
            level = lowest_prio + 3'(k + 1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/irq_priority_sequencer.sv
// ----------------------------------------------------------------------------
// Module : irq_priority_sequencer
// Brief  : IRR/ISR storage, rotating priority, INTA sequencing and OCW2 EOIs.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_priority_sequencer
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IR-1:0] ir,
   input  logic              ltim,
   input  logic              aeoi,
   input  logic [NUM_IR-1:0] imr,
   input  logic              ocw2_valid,
   input  logic [2:0]        ocw2_cmd,
   input  logic [2:0]        ocw2_level,
   input  logic              inta_n,
   output logic              int_out,
   output logic [NUM_IR-1:0] irr,
   output logic [NUM_IR-1:0] isr,
   output logic [1:0]        number_of_ack,
   output logic [2:0]        ack_level
);

   logic [SYNC_STAGES-1:0][NUM_IR-1:0] r_sync;
   logic [NUM_IR-1:0] r_irs_d;
   logic [NUM_IR-1:0] r_irr;
   logic [NUM_IR-1:0] r_isr;
   logic [2:0]        r_lowest;
   logic [2:0]        r_ack_level;
   logic              r_rot_aeoi;
   logic              r_spurious;
   logic              r_int_out;
   logic              r_inta_q;
   logic [1:0]        r_state;

   logic [NUM_IR-1:0] w_irs;
   logic [NUM_IR-1:0] w_pend;
   logic [NUM_IR-1:0] w_irr_nxt;
   logic [NUM_IR-1:0] w_isr_nxt;
   logic [NUM_IR-1:0] w_eoi_clr;
   logic [2:0]        w_lowest_nxt;
   logic [2:0]        w_rot_level;
   logic              w_rot_ocw;
   logic              w_rot_aeoi_nxt;
   logic              w_pend_valid;
   logic [2:0]        w_pend_level;
   logic              w_isr_valid;
   logic [2:0]        w_isr_level;
   logic              w_int_req;
   logic              w_fall;
   logic              w_rise;
   logic              w_take;
   logic              w_ack_done;
   logic              w_aeoi_clr;
   logic [1:0]        w_state_nxt;
   logic [1:0]        w_num_ack;

   assign w_irs  = r_sync[SYNC_STAGES-1];
   assign w_pend = r_irr & ~imr;

   priority_resolver u_pend_res (
      .req         (w_pend),
      .lowest_prio (r_lowest),
      .valid       (w_pend_valid),
      .level       (w_pend_level)
   );

   priority_resolver u_isr_res (
      .req         (r_isr),
      .lowest_prio (r_lowest),
      .valid       (w_isr_valid),
      .level       (w_isr_level)
   );

   // Fully nested: only a strictly higher-priority request may interrupt.
   assign w_int_req = w_pend_valid &&
                      (!w_isr_valid ||
                       (prio_rank(w_pend_level, r_lowest) < prio_rank(w_isr_level, r_lowest)));

   assign w_fall     = r_inta_q & ~inta_n;
   assign w_rise     = ~r_inta_q & inta_n;
   assign w_take     = (r_state == ST_IDLE) && w_fall;
   assign w_ack_done = (r_state == ST_ACK2) && w_rise;
   assign w_aeoi_clr = w_ack_done && aeoi && !r_spurious;

   // ---------------- INTA FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_fall) w_state_nxt = ST_ACK1;
         ST_ACK1: if (w_fall) w_state_nxt = ST_ACK2;
         ST_ACK2: if (w_rise) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_num_ack = 2'd0;
      case (r_state)
         ST_ACK1: w_num_ack = 2'd1;
         ST_ACK2: w_num_ack = 2'd2;
         default: w_num_ack = 2'd0;
      endcase
   end

   // ---------------- OCW2 decode ----------------
   always_comb begin
      w_eoi_clr      = '0;
      w_rot_ocw      = 1'b0;
      w_rot_level    = r_lowest;
      w_rot_aeoi_nxt = r_rot_aeoi;
      if (ocw2_valid) begin
         case (ocw2_cmd)
            OCW2_NS_EOI: if (w_isr_valid) w_eoi_clr[w_isr_level] = 1'b1;
            OCW2_S_EOI:  if (|r_isr) w_eoi_clr[ocw2_level] = 1'b1;
            OCW2_ROT_NS_EOI: begin
               if (w_isr_valid) begin
                  w_eoi_clr[w_isr_level] = 1'b1;
                  w_rot_ocw              = 1'b1;
                  w_rot_level            = w_isr_level;
               end
            end
            OCW2_ROT_S_EOI: begin
               if (|r_isr) begin
                  w_eoi_clr[ocw2_level] = 1'b1;
                  w_rot_ocw             = 1'b1;
                  w_rot_level           = ocw2_level;
               end
            end
            OCW2_SET_PRIO: begin
               w_rot_ocw   = 1'b1;
               w_rot_level = ocw2_level;
            end
            OCW2_ROT_AEOI_SET: w_rot_aeoi_nxt = 1'b1;
            OCW2_ROT_AEOI_CLR: w_rot_aeoi_nxt = 1'b0;
            OCW2_NOP:          w_rot_aeoi_nxt = r_rot_aeoi;
            default:           w_rot_aeoi_nxt = r_rot_aeoi;
         endcase
      end
   end

   // ---------------- IRR / ISR / priority next state ----------------
   always_comb begin
      w_irr_nxt = r_irr;
      for (int i = 0; i < NUM_IR; i++) begin
         if (ltim)           w_irr_nxt[i] = w_irs[i];
         else if (!w_irs[i]) w_irr_nxt[i] = 1'b0;
         else if (!r_irs_d[i]) w_irr_nxt[i] = 1'b1;
      end
      if (w_take && w_pend_valid) w_irr_nxt[w_pend_level] = 1'b0;
   end

   // EOI clears see the pre-update ISR; the ACK1 set is applied last and wins.
   always_comb begin
      w_isr_nxt = r_isr & ~w_eoi_clr;
      if (w_aeoi_clr)             w_isr_nxt[r_ack_level]  = 1'b0;
      if (w_take && w_pend_valid) w_isr_nxt[w_pend_level] = 1'b1;
   end

   always_comb begin
      w_lowest_nxt = r_lowest;
      if (w_rot_ocw)                     w_lowest_nxt = w_rot_level;
      else if (w_aeoi_clr && r_rot_aeoi) w_lowest_nxt = r_ack_level;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync      <= '0;
         r_irs_d     <= '0;
         r_irr       <= '0;
         r_isr       <= '0;
         r_lowest    <= 3'd7;
         r_ack_level <= SPURIOUS_LEVEL;
         r_rot_aeoi  <= 1'b0;
         r_spurious  <= 1'b0;
         r_int_out   <= 1'b0;
         r_inta_q    <= 1'b1;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], ir};
         r_irs_d    <= w_irs;
         r_irr      <= w_irr_nxt;
         r_isr      <= w_isr_nxt;
         r_lowest   <= w_lowest_nxt;
         r_rot_aeoi <= w_rot_aeoi_nxt;
         r_inta_q   <= inta_n;
         r_int_out  <= w_take ? 1'b0 : w_int_req;
         if (w_take) begin
            r_ack_level <= w_pend_valid ? w_pend_level : SPURIOUS_LEVEL;
            r_spurious  <= !w_pend_valid;
         end
      end
   end

   assign int_out       = r_int_out;
   assign irr           = r_irr;
   assign isr           = r_isr;
   assign number_of_ack = w_num_ack;
   assign ack_level     = r_ack_level;

endmodule

`default_nettype wire

// File: tb/tb_irq_priority_sequencer.sv
// ----------------------------------------------------------------------------
// Module : tb_irq_priority_sequencer
// Brief  : Directed self-checking bench for irq_priority_sequencer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irq_priority_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ir;
   logic       ltim;
   logic       aeoi;
   logic [7:0] imr;
   logic       ocw2_valid;
   logic [2:0] ocw2_cmd;
   logic [2:0] ocw2_level;
   logic       inta_n;
   logic       int_out;
   logic [7:0] irr;
   logic [7:0] isr;
   logic [1:0] number_of_ack;
   logic [2:0] ack_level;

   int checks = 0;
   int errors = 0;

   irq_priority_sequencer #(.SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ir            (ir),
      .ltim          (ltim),
      .aeoi          (aeoi),
      .imr           (imr),
      .ocw2_valid    (ocw2_valid),
      .ocw2_cmd      (ocw2_cmd),
      .ocw2_level    (ocw2_level),
      .inta_n        (inta_n),
      .int_out       (int_out),
      .irr           (irr),
      .isr           (isr),
      .number_of_ack (number_of_ack),
      .ack_level     (ack_level)
   );

   always #5 clk = ~clk;

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ocw2(input logic [2:0] c, input logic [2:0] l);
      ocw2_cmd = c; ocw2_level = l; ocw2_valid = 1'b1;
      @(negedge clk);
      ocw2_valid = 1'b0;
   endtask

   task automatic inta_fall();
      inta_n = 1'b0;
      @(negedge clk);
   endtask

   task automatic inta_rise();
      inta_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ir = '0; ltim = 1'b0; aeoi = 1'b0; imr = '0;
      ocw2_valid = 1'b0; ocw2_cmd = '0; ocw2_level = '0; inta_n = 1'b1;
      wait_n(2);
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL reset_irr: got %h want 00", irr); end
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h want 00", isr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", int_out); end
      checks++; if (number_of_ack !== 2'd0) begin errors++; $display("FAIL reset_noa: got %0d want 0", number_of_ack); end
      checks++; if (ack_level !== 3'd7) begin errors++; $display("FAIL reset_lvl: got %0d want 7", ack_level); end
      rst_n = 1'b1;
      wait_n(1);
   endtask

   task automatic test_edge_ack();
      ir = 8'h08;
      wait_n(2);
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL edge_lat2: got %h want 00", irr); end
      wait_n(1);
      checks++; if (irr !== 8'h08) begin errors++; $display("FAIL edge_lat3: got %h want 08", irr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL edge_int_early: got %b want 0", int_out); end
      wait_n(1);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL edge_int: got %b want 1", int_out); end
      inta_fall();
      checks++; if (isr !== 8'h08) begin errors++; $display("FAIL ack1_isr: got %h want 08", isr); end
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL ack1_irr: got %h want 00", irr); end
      checks++; if (number_of_ack !== 2'd1) begin errors++; $display("FAIL ack1_noa: got %0d want 1", number_of_ack); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL ack1_int: got %b want 0", int_out); end
      checks++; if (ack_level !== 3'd3) begin errors++; $display("FAIL ack1_lvl: got %0d want 3", ack_level); end
      inta_rise();
      checks++; if (number_of_ack !== 2'd1) begin errors++; $display("FAIL ack1_hold: got %0d want 1", number_of_ack); end
      inta_fall();
      checks++; if (number_of_ack !== 2'd2) begin errors++; $display("FAIL ack2_noa: got %0d want 2", number_of_ack); end
      inta_rise();
      checks++; if (number_of_ack !== 2'd0) begin errors++; $display("FAIL ackend_noa: got %0d want 0", number_of_ack); end
      checks++; if (isr !== 8'h08) begin errors++; $display("FAIL ackend_isr: got %h want 08", isr); end
   endtask

   task automatic test_nesting();
      ir = 8'h28;
      wait_n(5);
      checks++; if (irr !== 8'h20) begin errors++; $display("FAIL nest_irr5: got %h want 20", irr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_low_int: got %b want 0", int_out); end
      ir = 8'h2A;
      wait_n(4);
      checks++; if (irr !== 8'h22) begin errors++; $display("FAIL nest_irr1: got %h want 22", irr); end
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_high_int: got %b want 1", int_out); end
      inta_fall();
      checks++; if (ack_level !== 3'd1) begin errors++; $display("FAIL nest_lvl: got %0d want 1", ack_level); end
      checks++; if (isr !== 8'h0A) begin errors++; $display("FAIL nest_isr: got %h want 0A", isr); end
      inta_rise(); inta_fall(); inta_rise();
      ocw2(3'b001, 3'd0);
      checks++; if (isr !== 8'h08) begin errors++; $display("FAIL ns_eoi_isr: got %h want 08", isr); end
      checks++; if (irr !== 8'h20) begin errors++; $display("FAIL ns_eoi_irr: got %h want 20", irr); end
      ocw2(3'b011, 3'd3);
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL s_eoi_isr: got %h want 00", isr); end
      ir = 8'h00;
      wait_n(5);
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL nest_clr_irr: got %h want 00", irr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_clr_int: got %b want 0", int_out); end
   endtask

   task automatic test_mask_spurious();
      imr = 8'hFF; ir = 8'h04;
      wait_n(5);
      checks++; if (irr !== 8'h04) begin errors++; $display("FAIL mask_irr: got %h want 04", irr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL mask_int: got %b want 0", int_out); end
      inta_fall();
      checks++; if (ack_level !== 3'd7) begin errors++; $display("FAIL spur_lvl: got %0d want 7", ack_level); end
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", isr); end
      checks++; if (irr !== 8'h04) begin errors++; $display("FAIL spur_irr: got %h want 04", irr); end
      inta_rise(); inta_fall(); inta_rise();
      checks++; if (number_of_ack !== 2'd0) begin errors++; $display("FAIL spur_noa: got %0d want 0", number_of_ack); end
      ir = 8'h00;
      wait_n(4);
      imr = 8'h00;
      wait_n(1);
   endtask

   task automatic test_aeoi();
      aeoi = 1'b1;
      ocw2(3'b100, 3'd0);
      ir = 8'h40;
      wait_n(5);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL aeoi_int: got %b want 1", int_out); end
      inta_fall();
      checks++; if (isr !== 8'h40) begin errors++; $display("FAIL aeoi_ack1_isr: got %h want 40", isr); end
      inta_rise(); inta_fall();
      checks++; if (isr !== 8'h40) begin errors++; $display("FAIL aeoi_ack2_isr: got %h want 40", isr); end
      inta_rise();
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL aeoi_clr_isr: got %h want 00", isr); end
      ir = 8'h00;
      wait_n(4);
      ir = 8'h81;
      wait_n(5);
      inta_fall();
      checks++; if (isr !== 8'h80) begin errors++; $display("FAIL rot_aeoi_isr: got %h want 80", isr); end
      checks++; if (ack_level !== 3'd7) begin errors++; $display("FAIL rot_aeoi_lvl: got %0d want 7", ack_level); end
      checks++; if (irr !== 8'h01) begin errors++; $display("FAIL rot_aeoi_irr: got %h want 01", irr); end
      inta_rise(); inta_fall(); inta_rise();
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_aeoi_end: got %h want 00", isr); end
      ir = 8'h00;
      wait_n(5);
      ocw2(3'b000, 3'd0);
      aeoi = 1'b0;
   endtask

   task automatic test_rotation();
      ocw2(3'b110, 3'd2);
      ir = 8'h11;
      wait_n(5);
      checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL rot_int: got %b want 1", int_out); end
      inta_fall();
      checks++; if (ack_level !== 3'd4) begin errors++; $display("FAIL setprio_lvl: got %0d want 4", ack_level); end
      checks++; if (isr !== 8'h10) begin errors++; $display("FAIL setprio_isr: got %h want 10", isr); end
      inta_rise(); inta_fall(); inta_rise();
      ocw2(3'b111, 3'd4);
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_s_eoi_isr: got %h want 00", isr); end
      ir = 8'h21;
      wait_n(5);
      checks++; if (irr !== 8'h21) begin errors++; $display("FAIL rot_irr: got %h want 21", irr); end
      inta_fall();
      checks++; if (ack_level !== 3'd5) begin errors++; $display("FAIL rot_s_eoi_lvl: got %0d want 5", ack_level); end
      checks++; if (isr !== 8'h20) begin errors++; $display("FAIL rot_s_eoi_isr2: got %h want 20", isr); end
      inta_rise(); inta_fall(); inta_rise();
      ocw2(3'b001, 3'd0);
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_ns_eoi: got %h want 00", isr); end
      ir = 8'h00;
      wait_n(5);
      ocw2(3'b110, 3'd7);
   endtask

   task automatic test_level_mode();
      ltim = 1'b1; ir = 8'h04;
      wait_n(3);
      checks++; if (irr !== 8'h04) begin errors++; $display("FAIL lvl_irr: got %h want 04", irr); end
      wait_n(1);
      ocw2_cmd = 3'b011; ocw2_level = 3'd2; ocw2_valid = 1'b1;
      inta_fall();
      ocw2_valid = 1'b0;
      checks++; if (isr !== 8'h04) begin errors++; $display("FAIL lvl_ack_isr: got %h want 04", isr); end
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL lvl_take_irr: got %h want 00", irr); end
      inta_rise();
      checks++; if (irr !== 8'h04) begin errors++; $display("FAIL lvl_reset_irr: got %h want 04", irr); end
      inta_fall(); inta_rise();
      ocw2(3'b001, 3'd0);
      ir = 8'h00;
      wait_n(4);
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL lvl_drop_irr: got %h want 00", irr); end
      ltim = 1'b0;
      wait_n(1);
   endtask

   task automatic test_reset_mid_ack();
      ir = 8'h02;
      wait_n(5);
      inta_fall();
      checks++; if (isr !== 8'h02) begin errors++; $display("FAIL mid_pre_isr: got %h want 02", isr); end
      #2;
      rst_n = 1'b0; inta_n = 1'b1; ir = 8'h00;
      #1;
      checks++; if (isr !== 8'h00) begin errors++; $display("FAIL mid_isr: got %h want 00", isr); end
      checks++; if (number_of_ack !== 2'd0) begin errors++; $display("FAIL mid_noa: got %0d want 0", number_of_ack); end
      checks++; if (ack_level !== 3'd7) begin errors++; $display("FAIL mid_lvl: got %0d want 7", ack_level); end
      checks++; if (irr !== 8'h00) begin errors++; $display("FAIL mid_irr: got %h want 00", irr); end
      checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL mid_int: got %b want 0", int_out); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(2);
      checks++; if (number_of_ack !== 2'd0) begin errors++; $display("FAIL post_noa: got %0d want 0", number_of_ack); end
   endtask

   initial begin
      test_reset();
      test_edge_ack();
      test_nesting();
      test_mask_spurious();
      test_aeoi();
      test_rotation();
      test_level_mode();
      test_reset_mid_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
